// File: rtl/wfa_pkg.sv
// Shared types and default configuration for the weight-fetch arbiter.
package wfa_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } wfa_state_e;

   localparam int unsigned WFA_NUM_REQ    = 4;
   localparam int unsigned WFA_ADDR_WIDTH = 16;
   localparam int unsigned WFA_LEN_WIDTH  = 8;

endpackage

// File: rtl/wfa_rr_arbiter.sv
// Round-robin grant: first requester after ptr_i (wrapping) wins, one-hot out.
module wfa_rr_arbiter
   import wfa_pkg::*;
#(
   parameter int unsigned NUM_REQ = WFA_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         grant_o
);

   localparam int unsigned IDW = $clog2(NUM_REQ);

   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = IDW'((32'(ptr_i) + i) % NUM_REQ);
         if (!found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/weight_fetch_arbiter.sv
// Round-robin burst fetcher from a shared weight memory (1-cycle read latency).
// Optional macro WFA_BOUND_CHECK_EN rejects bursts crossing the top of memory and adds port err.
module weight_fetch_arbiter
   import wfa_pkg::*;
#(
   parameter int unsigned NUM_REQ    = WFA_NUM_REQ,
   parameter int unsigned ADDR_WIDTH = WFA_ADDR_WIDTH,
   parameter int unsigned LEN_WIDTH  = WFA_LEN_WIDTH
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   output logic [ADDR_WIDTH-1:0]         mem_read_addr,
   output logic                          mem_read_en,
   input  logic [7:0]                    mem_read_data,
   input  logic                          mem_read_valid,
   output logic [7:0]                    rsp_data,
   output logic                          rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
   output logic                          rsp_last,
`ifdef WFA_BOUND_CHECK_EN
   output logic                          err,
`endif
   output logic                          busy
);

   localparam int unsigned IDW = $clog2(NUM_REQ);

   wfa_state_e            state_q, state_d;
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  inflight_q;
   logic                  last_q;
   logic [IDW-1:0]        rsp_id_q;

   logic [NUM_REQ-1:0]    grant;
   logic [IDW-1:0]        win_idx;
   logic [ADDR_WIDTH-1:0] sel_base;
   logic [LEN_WIDTH-1:0]  sel_len;

`ifdef WFA_BOUND_CHECK_EN
   logic                  err_q, err_d;
   logic [ADDR_WIDTH:0]   end_addr;
   logic                  oob;
`endif

   wfa_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant)
   );

   // One-hot grant steers the winner's packed fields without a variable part-select.
   always_comb begin
      win_idx  = '0;
      sel_base = '0;
      sel_len  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_idx  = IDW'(i);
            sel_base = sel_base | req_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len  = sel_len  | req_len[i*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

`ifdef WFA_BOUND_CHECK_EN
   always_comb begin
      end_addr = {1'b0, sel_base} + (ADDR_WIDTH+1)'(sel_len);
      oob      = end_addr[ADDR_WIDTH];
   end
`endif

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      id_d          = id_q;
      base_d        = base_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      req_ready     = '0;
      mem_read_en   = 1'b0;
      mem_read_addr = '0;
`ifdef WFA_BOUND_CHECK_EN
      err_d         = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready = grant;
               ptr_d     = win_idx;
               id_d      = win_idx;
               base_d    = sel_base;
               len_d     = sel_len;
               cnt_d     = '0;
`ifdef WFA_BOUND_CHECK_EN
               if (oob) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
`else
               state_d = ISSUE;
`endif
            end
         end
         ISSUE: begin
            mem_read_en   = 1'b1;
            mem_read_addr = base_q + ADDR_WIDTH'(cnt_q);
            cnt_d         = cnt_q + LEN_WIDTH'(1);
            if (cnt_q == len_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ptr_q      <= IDW'(NUM_REQ - 1);
         id_q       <= '0;
         base_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         last_q     <= 1'b0;
         rsp_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         base_q     <= base_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         // Tracks the read issued last cycle; gates stray memory returns.
         inflight_q <= mem_read_en;
         last_q     <= mem_read_en && (cnt_q == len_q);
         rsp_id_q   <= id_q;
      end
   end

`ifdef WFA_BOUND_CHECK_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

   assign rsp_data  = mem_read_data;
   assign rsp_valid = mem_read_valid & inflight_q;
   assign rsp_last  = rsp_valid & last_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Scoreboard bench: driver predicts grants and response streams, monitor checks them.
module tb_weight_fetch_arbiter;

   localparam int NR = 4;
   localparam int AW = 16;
   localparam int LW = 8;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*AW-1:0]  req_base_addr;
   logic [NR*LW-1:0]  req_len;
   logic [AW-1:0]     mem_read_addr;
   logic              mem_read_en;
   logic [7:0]        mem_read_data;
   logic              mem_read_valid;
   logic [7:0]        rsp_data;
   logic              rsp_valid;
   logic [1:0]        rsp_id;
   logic              rsp_last;
   logic              busy;
`ifdef WFA_BOUND_CHECK_EN
   logic              err;
`endif

   logic              mem_v_q = 1'b0;
   logic [7:0]        mem_d_q = '0;
   logic              stray_valid = 1'b0;

   int                cyc = 0;
   int                n_chk = 0;
   int                n_pass = 0;
   int                rr_last = NR - 1;

   logic [AW-1:0]     tb_base [NR];
   logic [LW-1:0]     tb_len  [NR];

   typedef struct {
      logic [7:0] data;
      int         id;
      bit         last;
      int         cyc;
   } rsp_t;

   typedef struct {
      logic [AW-1:0] addr;
      int            cyc;
   } rd_t;

   rsp_t exp_q[$];
   rd_t  addr_q[$];

   weight_fetch_arbiter #(
      .NUM_REQ    (NR),
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_base_addr  (req_base_addr),
      .req_len        (req_len),
      .mem_read_addr  (mem_read_addr),
      .mem_read_en    (mem_read_en),
      .mem_read_data  (mem_read_data),
      .mem_read_valid (mem_read_valid),
      .rsp_data       (rsp_data),
      .rsp_valid      (rsp_valid),
      .rsp_id         (rsp_id),
      .rsp_last       (rsp_last),
`ifdef WFA_BOUND_CHECK_EN
      .err            (err),
`endif
      .busy           (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory returns the low address byte one cycle after each read strobe.
   always @(posedge clock) begin
      mem_v_q <= mem_read_en;
      mem_d_q <= mem_read_addr[7:0];
   end
   assign mem_read_valid = mem_v_q | stray_valid;
   assign mem_read_data  = mem_d_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int pick(input logic [NR-1:0] m, input int last);
      for (int i = 1; i <= NR; i++) begin
         int idx = (last + i) % NR;
         if (m[idx]) return idx;
      end
      return -1;
   endfunction

   // Monitor: every read strobe and response must match the oldest prediction.
   rsp_t mon_r;
   rd_t  mon_a;
   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (mem_read_en) begin
            if (addr_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_read: addr %0h at cycle %0d, none expected", mem_read_addr, cyc);
            end else begin
               mon_a = addr_q.pop_front();
               chk("read_addr", 32'(mem_read_addr), 32'(mon_a.addr));
               chk("read_cycle", cyc, mon_a.cyc);
            end
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_rsp: data %0h id %0d at cycle %0d, none expected", rsp_data, rsp_id, cyc);
            end else begin
               mon_r = exp_q.pop_front();
               chk("rsp_data", 32'(rsp_data), 32'(mon_r.data));
               chk("rsp_id", 32'(rsp_id), 32'(mon_r.id));
               chk("rsp_last", 32'(rsp_last), 32'(mon_r.last));
               chk("rsp_cycle", cyc, mon_r.cyc);
            end
         end
      end
   end

   task automatic drive_bus(input logic [NR-1:0] mask);
      req_valid = mask;
      for (int i = 0; i < NR; i++) begin
         req_base_addr[i*AW +: AW] = tb_base[i];
         req_len[i*LW +: LW]       = tb_len[i];
      end
   endtask

   // Present mask, wait for the grant, predict the burst; returns after the accept edge.
   task automatic issue(input logic [NR-1:0] mask, input bit push, output int w);
      bit got = 0;
      int acc;
      logic [AW-1:0] a;
      @(negedge clock);
      drive_bus(mask);
      w = pick(mask, rr_last);
      for (int t = 0; t < 50; t++) begin
         #1;
         if (req_ready != '0) begin
            got = 1;
            break;
         end
         @(negedge clock);
      end
      if (!got) begin
         n_chk++;
         $display("FAIL grant_timeout: got no req_ready, expected %0h", 1 << w);
         req_valid = '0;
         return;
      end
      chk("grant", 32'(req_ready), 32'(1) << w);
      acc = cyc;
      rr_last = w;
      if (push) begin
         for (int k = 0; k <= int'(tb_len[w]); k++) begin
            a = tb_base[w] + AW'(k);
            addr_q.push_back('{addr: a, cyc: acc + 1 + k});
            exp_q.push_back('{data: a[7:0], id: w, last: (k == int'(tb_len[w])), cyc: acc + 2 + k});
         end
      end
      @(posedge clock);
      #1 req_valid = '0;
   endtask

   task automatic wait_idle(input int len);
      int n = 0;
      bit done = 0;
      for (int t = 0; t < 600; t++) begin
         @(negedge clock);
         if (busy) n++;
         else begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         n_chk++;
         $display("FAIL idle_timeout: busy still 1, expected 0");
      end else begin
         // len+1 bytes issued plus one drain cycle
         chk("busy_cycles", n, len + 2);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 0);
      chk({tag, "_rd_en"}, 32'(mem_read_en), 0);
      chk({tag, "_rd_addr"}, 32'(mem_read_addr), 0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
      chk({tag, "_rsp_last"}, 32'(rsp_last), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      reset_n = 1'b0;
      req_valid = '0;
      req_base_addr = '0;
      req_len = '0;
      for (int i = 0; i < NR; i++) begin
         tb_base[i] = '0;
         tb_len[i]  = '0;
      end
      #2;
      chk_zero_outputs("reset");
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      // All four held valid, single bytes: rotation 0,1,2,3,0.
      for (int i = 0; i < NR; i++) begin
         tb_base[i] = AW'(16'h0100 * i + 16'h0040);
         tb_len[i]  = '0;
      end
      for (int r = 0; r < 5; r++) begin
         issue(4'b1111, 1, w);
         wait_idle(0);
      end

      // Single request from 0, base 0x10, 4 bytes.
      tb_base[0] = 16'h0010;
      tb_len[0]  = 8'd3;
      issue(4'b0001, 1, w);
      wait_idle(3);

      // Address wrap across the top of memory.
      tb_base[1] = 16'hFFFE;
      tb_len[1]  = 8'd3;
`ifdef WFA_BOUND_CHECK_EN
      issue(4'b0010, 0, w);
      chk("oob_err", 32'(err), 1);
      chk("oob_busy", 32'(busy), 0);
      chk("oob_rd_en", 32'(mem_read_en), 0);
      @(posedge clock);
      #1 chk("oob_err_pulse", 32'(err), 0);
`else
      issue(4'b0010, 1, w);
      wait_idle(3);
`endif

      // Maximum length burst.
      tb_base[2] = 16'h1234;
      tb_len[2]  = 8'hFF;
      issue(4'b0100, 1, w);
      wait_idle(255);

      // Randomized masks, bases and lengths.
      for (int r = 0; r < 40; r++) begin
         logic [NR-1:0] m;
         m = NR'($urandom_range(1, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) begin
            tb_base[i] = AW'($urandom_range(0, 16'hFFEF));
            tb_len[i]  = LW'($urandom_range(0, 15));
         end
         issue(m, 1, w);
         wait_idle(int'(tb_len[w]));
      end

      // Reset in the third cycle of an 8-byte burst.
      tb_base[2] = 16'h0200;
      tb_len[2]  = 8'd7;
      issue(4'b0100, 1, w);
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b0;
      #1 chk_zero_outputs("midreset");
      exp_q.delete();
      addr_q.delete();
      rr_last = NR - 1;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1 stray_valid = 1'b1;
      #1 chk("stray_rsp_valid", 32'(rsp_valid), 0);
      @(posedge clock);
      #1 stray_valid = 1'b0;

      for (int i = 0; i < NR; i++) begin
         tb_base[i] = AW'(16'h0300 + 16'h0010 * i);
         tb_len[i]  = 8'd1;
      end
      issue(4'b1111, 1, w);
      wait_idle(1);

      repeat (3) @(negedge clock);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("addr_q_drained", addr_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/weight_fetch_arbiter.md
WEIGHT_FETCH_ARBITER -- requirements
Module: weight_fetch_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, weight-memory address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst-length field width; encoding is bytes minus 1.
REQ-004 SHALL have port: clock  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: req_valid  in  NUM_REQ  per-requester burst request.
REQ-007 SHALL have port: req_ready  out  NUM_REQ  one-hot grant/accept pulse.
REQ-008 SHALL have port: req_base_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses; requester i at slice i.
REQ-009 SHALL have port: req_len  in  NUM_REQ*LEN_WIDTH  packed burst lengths minus 1.
REQ-010 SHALL have port: mem_read_addr  out  ADDR_WIDTH  weight-memory read address.
REQ-011 SHALL have port: mem_read_en  out  1  weight-memory read strobe.
REQ-012 SHALL have ports: mem_read_data  in  8, and mem_read_valid  in  1; memory returns data exactly 1 cycle after mem_read_en.
REQ-013 SHALL have ports: rsp_data  out  8, rsp_valid  out  1, rsp_id  out  $clog2(NUM_REQ), rsp_last  out  1, and busy  out  1.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-015 IDLE: if any req_valid, SHALL grant one requester round-robin, searching from (last_winner+1) mod NUM_REQ; after reset the search starts at requester 0.
REQ-016 Grant SHALL assert req_ready[winner] for exactly one cycle in IDLE, combinationally with req_valid; on that edge base, len and id SHALL be latched and the FSM SHALL enter ISSUE.
REQ-017 ISSUE: mem_read_en=1 every cycle; mem_read_addr=base+k for k=0..len; after the issue with k=len the FSM SHALL go to DRAIN.
REQ-018 DRAIN: SHALL hold mem_read_en=0 for one cycle while the final read returns, then go to IDLE.
REQ-019 Latency: for an accept at edge T, first mem_read_en is in cycle T+1 and first rsp_valid is in cycle T+2; a burst of N bytes occupies N+2 cycles from accept to IDLE.
REQ-020 rsp_valid SHALL equal mem_read_valid AND the internal in-flight flag; rsp_data SHALL equal mem_read_data; rsp_id SHALL be the latched id, pipelined 1 cycle.
REQ-021 rsp_last SHALL be asserted with the rsp_valid of the final byte of each burst only.
REQ-022 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-023 req_ready SHALL be 0 in ISSUE and DRAIN; requests arriving then SHALL wait, no queuing beyond req_valid hold.
REQ-024 Simultaneous requests SHALL be served one burst each in rotating order; no requester is starved beyond NUM_REQ-1 bursts.
REQ-025 len=0 SHALL mean one byte; len=2^LEN_WIDTH-1 SHALL mean 2^LEN_WIDTH bytes.
REQ-026 Address arithmetic SHALL be ADDR_WIDTH bits and wrap modulo 2^ADDR_WIDTH unless WFA_BOUND_CHECK_EN is defined.

Reset
REQ-027 On reset_n low, the block SHALL asynchronously force: FSM=IDLE, req_ready=0, mem_read_en=0, mem_read_addr=0, rsp_valid=0, rsp_id=0, rsp_last=0, busy=0, round-robin pointer=NUM_REQ-1, in-flight flag=0.
REQ-028 A reset mid-burst SHALL abort the burst; any mem_read_valid arriving after reset deassertion without a new issue SHALL be dropped.

Configuration
REQ-029 With macro WFA_BOUND_CHECK_EN defined, a request whose base+len exceeds 2^ADDR_WIDTH-1 SHALL still be accepted (one req_ready pulse), issue no reads, pulse output err (1 bit, reset 0) for one cycle, and return to IDLE.
REQ-030 Without WFA_BOUND_CHECK_EN, port err SHALL not exist and addresses SHALL wrap.

Structure
REQ-031 The package wfa_pkg SHALL hold the FSM state enum (IDLE, ISSUE, DRAIN) and the default parameter constants.
REQ-032 The round-robin grant logic SHALL be the sub-module wfa_rr_arbiter (req vector, pointer -> one-hot grant).

Verification
REQ-033 Single request: req 0, base=0x0010, len=3 -> reads at 0x10..0x13; rsp data 0x10..0x13 with id=0; rsp_last on 0x13; accept-to-first-rsp = 2 cycles.
REQ-034 All four requesters held valid, len=0 -> grants in order 0,1,2,3,0; each produces one rsp with the matching id.
REQ-035 Wrap: base=0xFFFE, len=3, macro off -> addresses FFFE, FFFF, 0000, 0001; data FE, FF, 00, 01.
REQ-036 Same wrap case with WFA_BOUND_CHECK_EN -> one err pulse, no mem_read_en, busy returns to 0.
REQ-037 Reset asserted in the 3rd cycle of a len=7 burst -> all outputs 0 immediately; the stray mem_read_valid produces no rsp_valid; the next request is granted from requester 0.
REQ-038 Max length: len=255 -> exactly 256 rsp_valid, rsp_last only on the 256th.
